// File: rtl/apple1_kbd_arbiter_pkg.sv
// Shared constants, source encoding and character normalisation for the
// Apple-1 keyboard arbiter.
package apple1_kbd_arbiter_pkg;

    localparam logic [6:0] ASCII_LF = 7'h0A;
    localparam logic [6:0] LC_LO    = 7'h61;
    localparam logic [6:0] LC_HI    = 7'h7A;
    localparam logic [6:0] CASE_OFS = 7'h20;
    localparam int         LEVEL_W  = 5;

    typedef enum logic {
        SRC_UART = 1'b0,
        SRC_PS2  = 1'b1
    } src_e;

    // Apple-1 ASCII is 7-bit; optionally fold lowercase to uppercase.
    function automatic logic [6:0] normalise(input logic [7:0] c, input logic upcase);
        logic [6:0] c7;
        c7 = c[6:0];
        if (upcase && (c7 >= LC_LO) && (c7 <= LC_HI))
            c7 = c7 - CASE_OFS;
        return c7;
    endfunction

endpackage

// File: rtl/apple1_kbd_arbiter_if.sv
// Character-source handshakes and CPU-side keyboard register view.
interface apple1_kbd_arbiter_if;
    logic       uart_valid;
    logic [7:0] uart_data;
    logic       uart_ready;
    logic       ps2_valid;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_select;
    logic       kbd_rd;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic [4:0] fifo_level;
    logic       overrun;

    modport master (
        output uart_valid, uart_data, ps2_valid, ps2_data, ps2_select, kbd_rd,
        input  uart_ready, ps2_ready, kbd_data, kbd_ready, fifo_level, overrun
    );

    modport slave (
        input  uart_valid, uart_data, ps2_valid, ps2_data, ps2_select, kbd_rd,
        output uart_ready, ps2_ready, kbd_data, kbd_ready, fifo_level, overrun
    );
endinterface

// File: rtl/apple1_kbd_arbiter_kbd_fifo.sv
// Small character FIFO with combinational head, occupancy count and
// asynchronous clear of its control state.
module kbd_fifo #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 7,
    parameter int LEVEL_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   rd_data,
    output logic [LEVEL_W-1:0] level,
    output logic               empty,
    output logic               full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is not reset; only pointers and count carry meaning.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);
    assign full    = (level == LEVEL_W'(DEPTH));
endmodule

// File: rtl/apple1_kbd_arbiter.sv
// Round-robin merge of UART and PS/2 characters into the Apple-1 KBD/KBDCR
// register pair, with normalisation and a small FIFO in between.
module apple1_kbd_arbiter
    import apple1_kbd_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit UPCASE     = 1'b1
) (
    input  logic                 clk25,
    input  logic                 rst,
    apple1_kbd_arbiter_if.slave  bus
);
    logic               uart_req;
    logic               ps2_req;
    logic               grant_uart;
    logic               grant_ps2;
    logic               accept;
    logic               overrun_set;
    logic               push;
    logic               pop;
    logic [7:0]         byte_in;
    logic [6:0]         char7;
    logic [6:0]         head;
    logic [LEVEL_W-1:0] level;
    logic               full;
    logic               empty;
    src_e               last_grant;
    logic [7:0]         kbd_data_q;
    logic               kbd_ready_q;
    logic               overrun_q;

    always_comb begin
        uart_req    = bus.uart_valid;
        ps2_req     = bus.ps2_valid & bus.ps2_select;
        grant_uart  = uart_req & (~ps2_req | (last_grant == SRC_PS2));
        grant_ps2   = ps2_req & (~uart_req | (last_grant == SRC_UART));
        accept      = (grant_uart | grant_ps2) & ~full;
        overrun_set = (grant_uart | grant_ps2) & full;
        byte_in     = grant_uart ? bus.uart_data : bus.ps2_data;
        char7       = normalise(byte_in, UPCASE);
        // LF completes its handshake but is dropped before the FIFO.
        push        = accept & (char7 != ASCII_LF);
        pop         = ~kbd_ready_q & ~empty;
    end

    kbd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (7),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk     (clk25),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (char7),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    // Output register: a read clears ready; the next character loads one edge later.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            last_grant  <= SRC_PS2;
            kbd_data_q  <= 8'h80;
            kbd_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (accept)
                last_grant <= grant_uart ? SRC_UART : SRC_PS2;
            if (overrun_set)
                overrun_q <= 1'b1;
            if (pop) begin
                kbd_data_q  <= {1'b1, head};
                kbd_ready_q <= 1'b1;
            end else if (bus.kbd_rd && kbd_ready_q) begin
                kbd_ready_q <= 1'b0;
            end
        end
    end

    assign bus.uart_ready = grant_uart & ~full;
    assign bus.ps2_ready  = grant_ps2 & ~full;
    assign bus.kbd_data   = kbd_data_q;
    assign bus.kbd_ready  = kbd_ready_q;
    assign bus.fifo_level = level;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_apple1_kbd_arbiter.sv
// Scoreboard bench: a queue-level reference predicts handshakes and occupancy,
// and a monitor checks each character the CPU reads against the expected order.
module tb_apple1_kbd_arbiter;
    localparam int DEPTH = 4;
    localparam bit UPC   = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apple1_kbd_arbiter_if bus();

    apple1_kbd_arbiter #(.FIFO_DEPTH(DEPTH), .UPCASE(UPC)) dut (
        .clk25 (clk),
        .rst   (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    int m_cnt;
    bit m_outv;
    bit m_ovr;
    bit m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] c);
        int v;
        v = int'(c) % 128;
        if (UPC && v >= 97 && v <= 122)
            v = v - 32;
        return 8'(v + 128);
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_outv = 1'b0;
        m_ovr  = 1'b0;
        m_last = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        bus.uart_valid = 1'b0;
        bus.uart_data  = 8'h00;
        bus.ps2_valid  = 1'b0;
        bus.ps2_data   = 8'h00;
        bus.ps2_select = 1'b0;
        bus.kbd_rd     = 1'b0;
    endtask

    task automatic step(input bit uv, input logic [7:0] ud, input bit pv,
                        input logic [7:0] pd, input bit sel, input bit rd);
        bit pv2, gu, gp, full, acc, pop, rdv;
        logic [7:0] c;
        @(negedge clk);
        chk("kbd_ready", 32'(bus.kbd_ready), 32'(m_outv));
        chk("fifo_level", 32'(bus.fifo_level), 32'(m_cnt));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        bus.uart_valid = uv;
        bus.uart_data  = ud;
        bus.ps2_valid  = pv;
        bus.ps2_data   = pd;
        bus.ps2_select = sel;
        bus.kbd_rd     = rd;
        #1;
        pv2  = pv && sel;
        full = (m_cnt == DEPTH);
        gu   = uv && (!pv2 || m_last);
        gp   = pv2 && (!uv || !m_last);
        chk("uart_ready", 32'(bus.uart_ready), 32'(gu && !full));
        chk("ps2_ready", 32'(bus.ps2_ready), 32'(gp && !full));
        acc = (gu || gp) && !full;
        if ((gu || gp) && full)
            m_ovr = 1'b1;
        pop = !m_outv && (m_cnt > 0);
        rdv = rd && m_outv;
        if (pop) begin
            m_cnt--;
            m_outv = 1'b1;
        end else if (rdv) begin
            m_outv = 1'b0;
        end
        if (acc) begin
            c = model_char(gu ? ud : pd);
            m_last = gp;
            if (c != 8'h8A) begin
                exp_q.push_back(c);
                m_cnt++;
            end
        end
    endtask

    // Monitor: every CPU read of a waiting character must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.kbd_rd && bus.kbd_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL read: actual=%0h required=no character", bus.kbd_data);
                end else begin
                    chk("kbd_data", 32'(bus.kbd_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        drive_idle();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_kbd_data", 32'(bus.kbd_data), 32'h80);
        chk("rst_kbd_ready", 32'(bus.kbd_ready), 32'h0);
        chk("rst_fifo_level", 32'(bus.fifo_level), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        rst = 1'b0;

        // Single lowercase character, then one read.
        step(1'b1, 8'h61, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_kbd_data", 32'(bus.kbd_data), 32'hC1);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Both sources continuously valid: alternation.
        repeat (12) step(1'b1, 8'h41, 1'b1, 8'h42, 1'b1, 1'b1);
        repeat (16) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // PS/2 disabled.
        repeat (4) step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1);

        // LF is swallowed, CR is delivered.
        step(1'b0, 8'h00, 1'b1, 8'h0A, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 8'h0D, 1'b1, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_kbd_data", 32'(bus.kbd_data), 32'h8D);
        repeat (4) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

        // Overfill with no reads.
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'h30 + i), 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_fifo_level", 32'(bus.fifo_level), 32'd4);
        chk("t3_overrun", 32'(bus.overrun), 32'h1);
        chk("t3_kbd_data", 32'(bus.kbd_data), 32'hB0);
        repeat (16) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ud, pd;
            ud = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            pd = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom);
            step($urandom_range(0, 3) != 0, ud, $urandom_range(0, 3) != 0, pd,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end
        repeat (20) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with characters in flight.
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'(8'h61 + i), 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_pre_level", 32'(bus.fifo_level), 32'd3);
        chk("t6_pre_ready", 32'(bus.kbd_ready), 32'h1);
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_kbd_ready", 32'(bus.kbd_ready), 32'h0);
        chk("t6_fifo_level", 32'(bus.fifo_level), 32'h0);
        chk("t6_kbd_data", 32'(bus.kbd_data), 32'h80);
        chk("t6_overrun", 32'(bus.overrun), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Recovery after reset; UART wins the first tie again.
        step(1'b1, 8'h7A, 1'b1, 8'h31, 1'b1, 1'b0);
        step(1'b1, 8'h7A, 1'b1, 8'h31, 1'b1, 1'b0);
        repeat (8) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
